// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands plus carry-in, one bit per clock.
module serial_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-2:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  logic             w_s;
  logic             w_c;
  logic             w_last;
  logic [WIDTH-1:0] w_res_sh;

  // One full-adder bit slice on the current LSBs and running carry
  always_comb begin
    w_s      = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
    w_c      = (r_a_sr[0] & r_b_sr[0]) | (r_a_sr[0] & r_carry) | (r_b_sr[0] & r_carry);
    w_last   = (r_cnt == CW'(WIDTH - 1));
    w_res_sh = {w_s, r_res};
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_SHIFT;
      S_SHIFT: if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register with status flags decoded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == S_SHIFT);
      r_done  <= (w_next == S_DONE);
    end
  end

  // Operand capture, bit-serial shifting and result latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
          end
        end
        S_SHIFT: begin
          r_a_sr  <= r_a_sr >> 1;
          r_b_sr  <= r_b_sr >> 1;
          r_res   <= w_res_sh[WIDTH-1:1];
          r_carry <= w_c;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_sum  <= w_res_sh;
            r_cout <= w_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=4) against an arithmetic reference.
module tb_serial_adder;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] last_sum  = '0;
  logic         last_cout = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: quiet inputs after acceptance; 1: random noise on start/operands; 2: operands forced to A
  task automatic do_add(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc, input int mode);
    logic [W:0] e;
    e = (W+1)'(ta) + (W+1)'(tb_) + (W+1)'(tc);
    a = ta; b = tb_; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    start = (mode == 1) ? 1'($urandom) : 1'b0;
    if (mode == 1) begin a = W'($urandom); b = W'($urandom); cin = 1'($urandom); end
    if (mode == 2) begin a = 4'hA; b = 4'hA; end
    for (int i = 0; i < int'(W); i++) begin
      chk("busy_shift", 32'(busy), 32'd1);
      chk("done_shift", 32'(done), 32'd0);
      chk("sum_hold", 32'(sum), 32'(last_sum));
      chk("cout_hold", 32'(cout), 32'(last_cout));
      @(posedge clk); #1;
      if (mode == 1) begin start = 1'($urandom); a = W'($urandom); b = W'($urandom); end
    end
    start = 1'b0;
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_done", 32'(busy), 32'd0);
    chk("sum", 32'(sum), 32'(e[W-1:0]));
    chk("cout", 32'(cout), 32'(e[W]));
    last_sum  = e[W-1:0];
    last_cout = e[W];
    @(posedge clk); #1;
    chk("done_width", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    // Asynchronous reset, checked before any clock edge
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // First start after reset, then directed cases
    do_add(4'h5, 4'h3, 1'b0, 0);
    do_add(4'hF, 4'hF, 1'b1, 0);
    do_add(4'hF, 4'h0, 1'b1, 0);
    // Operands change right after acceptance
    do_add(4'h1, 4'h1, 1'b0, 2);

    // start held high continuously: one result every W+2 cycles
    a = 4'h2; b = 4'h1; cin = 1'b0; start = 1'b1;
    for (int n = 1; n <= 18; n++) begin
      @(posedge clk); #1;
      chk("cont_done", 32'(done), 32'((n % 6) == 5));
      chk("cont_busy", 32'(busy), 32'(((n % 6) >= 1) && ((n % 6) <= 4)));
      if ((n % 6) == 5) chk("cont_sum", 32'(sum), 32'h3);
    end
    start = 1'b0;
    last_sum = 4'h3; last_cout = 1'b0;
    @(posedge clk); #1;
    chk("cont_idle", 32'(busy), 32'd0);

    // Reset during the second SHIFT cycle aborts immediately
    a = 4'h7; b = 4'h6; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_cout", 32'(cout), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_sum = '0; last_cout = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_no_busy", 32'(busy), 32'd0);
    end
    do_add(4'h9, 4'h9, 1'b1, 0);

    // Exhaustive sweep
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      do_add(v[3:0], v[7:4], v[8], 0);
    end

    // Random operands with noise on inputs while busy
    for (int i = 0; i < 40; i++)
      do_add(W'($urandom), W'($urandom), 1'($urandom), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 4, operand and sum width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to begin an addition; sampled on rising clk.
REQ-005 a  input  WIDTH  operand A; captured only when start is accepted.
REQ-006 b  input  WIDTH  operand B; captured only when start is accepted.
REQ-007 cin  input  1  carry-in; captured only when start is accepted.
REQ-008 busy  output  1  high while an addition is in progress.
REQ-009 done  output  1  single-cycle pulse marking a valid result.
REQ-010 sum  output  WIDTH  registered result, {cout,sum} = a+b+cin.
REQ-011 cout  output  1  registered carry-out of the addition.

Function
REQ-012 FSM states SHALL be IDLE, SHIFT and DONE; the encoding is free.
REQ-013 In IDLE with start=1 at a rising edge, the block SHALL load a, b and cin into internal shift and carry registers, clear the bit counter and enter SHIFT.
REQ-014 In IDLE with start=0 the block SHALL remain in IDLE.
REQ-015 In SHIFT, each cycle SHALL compute one bit: s = a_sr[0]^b_sr[0]^c, c_next = majority(a_sr[0],b_sr[0],c).
REQ-016 In SHIFT, each cycle SHALL shift a_sr and b_sr right by one, shift s into the result register from the MSB side and increment the counter.
REQ-017 After exactly WIDTH SHIFT cycles the block SHALL enter DONE.
REQ-018 On the edge entering DONE, sum SHALL take the completed result and cout SHALL take the final carry.
REQ-019 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-020 busy SHALL be 1 in SHIFT only; done SHALL be 1 in DONE only; the two are never high together.
REQ-021 Latency: if start is accepted at edge k, done SHALL be high in the cycle after edge k+WIDTH.
REQ-022 start while in SHIFT or DONE SHALL be ignored, with no queuing.
REQ-023 A start asserted in the cycle after done (back in IDLE) SHALL be accepted normally.
REQ-024 Changes on a, b or cin after acceptance SHALL NOT affect the result in progress.
REQ-025 sum and cout SHALL hold their last value until the next completion and SHALL NOT change on a new start.
REQ-026 Overflow SHALL be reported only via cout; sum wraps modulo 2^WIDTH.

Reset
REQ-027 While rst=1, the state SHALL be IDLE and busy, done, sum, cout, the counter, the shift registers and the carry register SHALL all be 0, independent of clk.
REQ-028 Reset asserted mid-operation SHALL abort the addition immediately, and no done pulse SHALL follow.
REQ-029 After rst deasserts, the first rising edge with start=1 SHALL be accepted.

Verification
REQ-030 WIDTH=4; a=4'h5, b=4'h3, cin=0, start pulse at edge k -> busy high for 4 cycles, then done at cycle k+5 with sum=4'h8 and cout=0.
REQ-031 a=4'hF, b=4'hF, cin=1 -> sum=4'hF, cout=1; a=4'hF, b=4'h0, cin=1 -> sum=4'h0, cout=1.
REQ-032 start held high continuously from a=4'h2, b=4'h1 -> one result (sum=4'h3) every 6 cycles; starts during busy or done are ignored.
REQ-033 Operands changed to 4'hA and 4'hA one cycle after acceptance of a=4'h1, b=4'h1 -> sum=4'h2.
REQ-034 rst pulsed in the 2nd SHIFT cycle -> all outputs 0 at once, no done pulse; a new start then yields a correct result.
REQ-035 Exhaustive sweep of all a, b and cin for WIDTH=4 -> every {cout,sum} equals a+b+cin and each done is exactly one cycle wide.
